// File: rtl/ubx_uart_rx_pkg.sv
// Shared definitions for the ubx_uart_rx receiver: FSM state encoding,
// UART line idle level and the default bit period used by the system wrapper.
package ubx_uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_t;

   // Level of an idle UART line (also the level of a good stop bit).
   localparam logic C_UART_IDLE = 1'b1;

   // 100 MHz / 115200 baud.
   localparam int C_CLKS_PER_BIT = 868;

endpackage

// File: rtl/ubx_uart_rx_sync_2ff.sv
// Dual-rank synchronizer for asynchronous inputs. Kept as its own module so
// both ranks can be constrained together. Resets to all ones (idle line).
module ubx_sync_2ff #(
   parameter int G_width = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [G_width-1:0] d,
   output logic [G_width-1:0] q
);

   logic [G_width-1:0] meta;

   // Two back-to-back flops; the first may go metastable, the second settles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         // NOTE: non-blocking so both ranks update from pre-edge values; blocking would collapse them into one flop.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ubx_uart_rx.sv
// 8N1 UART receiver feeding the UBX parser. Samples each bit at its centre,
// presents every good byte for one cycle and flags frames with a low stop bit.
// No backpressure: the consumer must accept data whenever o_data_tvalid is high.
module ubx_uart_rx
   import ubx_uart_rx_pkg::*;
#(
   parameter int G_clks_per_bit = C_CLKS_PER_BIT,
   parameter int G_cnt_width    = 16
) (
   input  logic       i_uart_clk,
   input  logic       i_Reset,
   input  logic       i_rx_serial,
   output logic [7:0] o_data_tdata,
   output logic       o_data_tvalid,
   output logic       o_frame_err,
   output logic       o_busy
);

   // Counter compare points: middle of the start bit, and one full bit period.
   localparam logic [G_cnt_width-1:0] C_HALF_M1 = G_cnt_width'(G_clks_per_bit / 2 - 1);
   localparam logic [G_cnt_width-1:0] C_FULL_M1 = G_cnt_width'(G_clks_per_bit - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic                   rx_s;
   logic [G_cnt_width-1:0] cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;

   logic half_hit;
   logic full_hit;
   logic cnt_clr;
   logic cnt_inc;
   logic bit_clr;
   logic bit_inc;
   logic shift_en;
   logic valid_set;
   logic err_set;
   logic busy_nxt;

   ubx_sync_2ff #(
      .G_width (1)
   ) u_sync (
      .clk (i_uart_clk),
      .rst (i_Reset),
      .d   (i_rx_serial),
      .q   (rx_s)
   );

   assign half_hit = (cnt == C_HALF_M1);
   assign full_hit = (cnt == C_FULL_M1);

   // State register.
   always_ff @(posedge i_uart_clk or posedge i_Reset) begin
      if (i_Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: after a good stop bit go straight to IDLE so a
   // start edge immediately following the stop bit is not missed.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         ST_IDLE:      if (rx_s != C_UART_IDLE) state_nxt = ST_START;
         ST_START:     if (half_hit) state_nxt = (rx_s == C_UART_IDLE) ? ST_IDLE : ST_DATA;
         ST_DATA:      if (full_hit && (bit_idx == 3'd7)) state_nxt = ST_STOP;
         ST_STOP:      if (full_hit) state_nxt = (rx_s == C_UART_IDLE) ? ST_IDLE : ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (rx_s == C_UART_IDLE) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Output/control decode: datapath strobes and next values of the pulsed outputs.
   always_comb begin
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      bit_clr   = 1'b0;
      bit_inc   = 1'b0;
      shift_en  = 1'b0;
      valid_set = 1'b0;
      err_set   = 1'b0;
      busy_nxt  = (state_nxt != ST_IDLE);
      unique case (state)
         ST_IDLE: begin
            cnt_clr = (rx_s != C_UART_IDLE);
         end
         ST_START: begin
            if (half_hit) begin
               cnt_clr = 1'b1;
               bit_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_DATA: begin
            if (full_hit) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               bit_inc  = (bit_idx != 3'd7);
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_STOP: begin
            if (full_hit) begin
               cnt_clr   = 1'b1;
               valid_set = (rx_s == C_UART_IDLE);
               err_set   = (rx_s != C_UART_IDLE);
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath: bit-period counter, bit index, shift register and registered outputs.
   always_ff @(posedge i_uart_clk or posedge i_Reset) begin
      if (i_Reset) begin
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         o_data_tdata  <= '0;
         o_data_tvalid <= 1'b0;
         o_frame_err   <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
         end

         if (bit_clr) begin
            bit_idx <= '0;
         end else if (bit_inc) begin
            bit_idx <= bit_idx + 3'd1;
         end

         if (shift_en) begin
            shreg[bit_idx] <= rx_s;
         end

         // tdata only moves together with a tvalid pulse, otherwise it holds.
         if (valid_set) begin
            o_data_tdata <= shreg;
         end

         o_data_tvalid <= valid_set;
         o_frame_err   <= err_set;
         o_busy        <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_ubx_uart_rx.sv
// Self-checking bench for ubx_uart_rx with 16 clocks per bit. A behavioural
// transmitter drives the line; expected bytes are queued as frames are sent
// and compared against the bytes captured from o_data_tvalid pulses.
module tb_ubx_uart_rx;

   localparam int CLKS   = 16;
   localparam int HALF   = CLKS / 2;
   localparam int CLK_T  = 100;                  // time units per clock
   localparam int BIT_T  = CLKS * CLK_T;         // exact bit period
   localparam int FAST_T = 1568;                 // 15.68 clocks per bit
   localparam int SLOW_T = 1632;                 // 16.32 clocks per bit
   localparam int LAT    = 3 + HALF + 9 * CLKS;  // E0 to tvalid capture edge
   localparam int FRAME  = 10 * CLKS;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] tdata;
   logic       tvalid;
   logic       ferr;
   logic       busy;

   int tests = 0;
   int fails = 0;

   int         cyc = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         got_t[$];
   int         err_cnt = 0;
   int         overlap_cnt = 0;
   int         hold_cnt = 0;
   logic [7:0] prev_tdata;

   ubx_uart_rx #(
      .G_clks_per_bit (CLKS),
      .G_cnt_width    (16)
   ) dut (
      .i_uart_clk    (clk),
      .i_Reset       (rst),
      .i_rx_serial   (rx),
      .o_data_tdata  (tdata),
      .o_data_tvalid (tvalid),
      .o_frame_err   (ferr),
      .o_busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #(CLK_T / 2) clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: captures bytes with the edge a downstream flop would take them.
   always @(negedge clk) begin
      if (tvalid) begin
         got_q.push_back(tdata);
         got_t.push_back(cyc + 1);
      end
      if (ferr) err_cnt++;
      if (tvalid && ferr) overlap_cnt++;
      if (!rst && !tvalid && (tdata !== prev_tdata)) hold_cnt++;
      prev_tdata = tdata;
   end

   // Serial transmitter; leaves the line at the stop-bit level.
   task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_bit);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_t);
      end
      rx = stop_bit;
      #(bit_t);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (tdata !== 8'h00) begin fails++; $display("FAIL reset_tdata: got %h expected 00", tdata); end
      tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
      tests++; if (ferr !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_single();
      int e0;
      int eb;
      got_q.delete(); got_t.delete(); exp_q.delete();
      eb = err_cnt;
      @(posedge clk); #1;
      e0 = cyc + 1;
      exp_q.push_back(8'hB5);
      send_frame(8'hB5, BIT_T, 1'b1);
      repeat (40) @(posedge clk);
      @(negedge clk);
      tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL single_data: got %h expected %h", got_q[0], exp_q[0]); end
         tests++; if ((got_t[0] - e0) !== LAT) begin fails++; $display("FAIL single_latency: got %0d expected %0d", got_t[0] - e0, LAT); end
      end
      tests++; if (tdata !== 8'hB5) begin fails++; $display("FAIL single_hold: got %h expected b5", tdata); end
      tests++; if (err_cnt - eb !== 0) begin fails++; $display("FAIL single_ferr: got %0d expected 0", err_cnt - eb); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [6];
      int eb;
      seq = '{8'hB5, 8'h62, 8'h01, 8'h07, 8'h5C, 8'h00};
      got_q.delete(); got_t.delete(); exp_q.delete();
      eb = err_cnt;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(seq[i]);
         send_frame(seq[i], BIT_T, 1'b1);
      end
      repeat (40) @(posedge clk);
      @(negedge clk);
      tests++; if (got_q.size() !== 6) begin fails++; $display("FAIL b2b_count: got %0d expected 6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
         if (i > 0) begin
            tests++; if ((got_t[i] - got_t[i-1]) !== FRAME) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, got_t[i] - got_t[i-1], FRAME); end
         end
      end
      tests++; if (err_cnt - eb !== 0) begin fails++; $display("FAIL b2b_ferr: got %0d expected 0", err_cnt - eb); end
   endtask

   task automatic test_glitch();
      int eb;
      got_q.delete(); got_t.delete(); exp_q.delete();
      eb = err_cnt;
      @(posedge clk); #1 rx = 1'b0;
      repeat (5) @(posedge clk);
      #1 rx = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
      repeat (9) @(posedge clk);
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
      repeat (40) @(posedge clk);
      tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL glitch_tvalid: got %0d bytes expected 0", got_q.size()); end
      tests++; if (err_cnt - eb !== 0) begin fails++; $display("FAIL glitch_ferr: got %0d expected 0", err_cnt - eb); end
   endtask

   task automatic test_frame_err();
      int eb;
      got_q.delete(); got_t.delete(); exp_q.delete();
      eb = err_cnt;
      @(posedge clk); #1;
      send_frame(8'h55, BIT_T, 1'b0);
      #(40 * BIT_T);
      rx = 1'b1;
      #(2 * BIT_T);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, BIT_T, 1'b1);
      repeat (40) @(posedge clk);
      @(negedge clk);
      tests++; if (err_cnt - eb !== 1) begin fails++; $display("FAIL ferr_pulses: got %0d expected 1", err_cnt - eb); end
      tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL ferr_next_data: got %h expected %h", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      int eb;
      b = 8'h3C;
      got_q.delete(); got_t.delete(); exp_q.delete();
      eb = err_cnt;
      @(posedge clk); #1;
      rx = 1'b0;
      #(BIT_T);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         #(BIT_T);
      end
      rx = b[4];
      #(BIT_T / 2);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (tdata !== 8'h00) begin fails++; $display("FAIL rstmid_tdata: got %h expected 00", tdata); end
      tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid: got %b expected 0", tvalid); end
      tests++; if (ferr !== 1'b0) begin fails++; $display("FAIL rstmid_ferr: got %b expected 0", ferr); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      repeat (17) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      exp_q.push_back(b);
      send_frame(b, BIT_T, 1'b1);
      repeat (40) @(posedge clk);
      @(negedge clk);
      tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL rstmid_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL rstmid_data: got %h expected %h", got_q[0], exp_q[0]); end
      end
      tests++; if (err_cnt - eb !== 0) begin fails++; $display("FAIL rstmid_ferr_cnt: got %0d expected 0", err_cnt - eb); end
   endtask

   task automatic test_baud(input int bit_t);
      int eb;
      int bad;
      got_q.delete(); got_t.delete(); exp_q.delete();
      eb  = err_cnt;
      bad = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(8'(i));
         send_frame(8'(i), bit_t, 1'b1);
      end
      repeat (40) @(posedge clk);
      @(negedge clk);
      tests++; if (got_q.size() !== 256) begin fails++; $display("FAIL baud%0d_count: got %0d expected 256", bit_t, got_q.size()); end
      for (int i = 0; i < 256 && i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== exp_q[i]) begin
            fails++;
            bad++;
            if (bad <= 4) $display("FAIL baud%0d_data[%0d]: got %h expected %h", bit_t, i, got_q[i], exp_q[i]);
         end
      end
      tests++; if (err_cnt - eb !== 0) begin fails++; $display("FAIL baud%0d_ferr: got %0d expected 0", bit_t, err_cnt - eb); end
   endtask

   task automatic test_invariants();
      tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL tvalid_ferr_overlap: got %0d expected 0", overlap_cnt); end
      tests++; if (hold_cnt !== 0) begin fails++; $display("FAIL tdata_hold: got %0d changes expected 0", hold_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_baud(FAST_T);
      rx = 1'b1;
      repeat (20) @(posedge clk);
      test_baud(SLOW_T);
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
